flash_read_sequencer: RTL and testbench
=======================================

# flash_read_sequencer

Timed read sequencer between the cartridge/MBC address logic and the external 16-bit parallel NOR flash. It accepts byte-address read requests and drives the flash control pins through a setup/wait/capture sequence with a parameterised access time. It returns the selected byte with a one-cycle valid pulse. This replaces the fixed, always-enabled asynchronous flash read in the cartridge path with a bounded-latency handshake.

## Interface
Parameters:
- P_WAIT_CYCLES, 4: flash access time in I_CLK cycles, counted from OE_L asserting to data capture; 0 behaves as 1.

Ports:
- I_CLK  in  1  system clock; the only clock.
- I_RESET  in  1  synchronous, active-high reset.
- I_REQ  in  1  read request; sampled only in IDLE.
- I_ADDR  in  24  byte address in flash space, including the game base offset; sampled with I_REQ.
- I_FLUSH  in  1  invalidates the last-word cache; pulse when the game select changes.
- O_BUSY  out  1  high in any state other than IDLE.
- O_DATA_VALID  out  1  one-cycle pulse; O_DATA is valid while it is high.
- O_DATA  out  8  returned byte; holds its value until the next capture.
- I_FLASH_DATA  in  16  flash data bus.
- O_FLASH_ADDR  out  24  flash word address = {1'b0, addr[23:1]}.
- O_FLASH_CLK  out  1  tied 1 (asynchronous mode).
- O_ADDR_VALID_L  out  1  low in SETUP only.
- O_FLASH_CE_L  out  1  low in SETUP and WAIT.
- O_FLASH_OE_L  out  1  low in WAIT only.
- O_FLASH_WE_L  out  1  tied 1; writes are never issued.

## Operation
- State machine: IDLE, SETUP, WAIT, DONE. Flash control outputs are registered and decoded from the state.
- IDLE:
  - On I_REQ=1, latch I_ADDR into addr_q and drive O_FLASH_ADDR.
  - On a cache hit, go to DONE. Otherwise go to SETUP.
- SETUP: lasts one cycle, then WAIT. The wait counter loads max(P_WAIT_CYCLES,1)-1.
- WAIT: the counter decrements each cycle. At count 0:
  - Capture I_FLASH_DATA.
  - Set O_DATA = addr_q[0] ? data[15:8] : data[7:0].
  - Assert O_DATA_VALID and go to DONE.
- DONE: O_DATA_VALID=1 for one cycle, then IDLE. I_REQ is ignored in DONE.
- O_FLASH_ADDR holds its last value in IDLE.
- Byte select: addr_q[0]=0 selects the low byte, 1 selects the high byte.
- Counter width: $clog2(P_WAIT_CYCLES+1) bits, minimum 1. It never wraps because it is reloaded on every entry to WAIT.
- Reset values:
  - State IDLE.
  - O_BUSY=0, O_DATA_VALID=0, O_DATA=8'h00, O_FLASH_ADDR=0.
  - O_FLASH_CE_L=1, O_FLASH_OE_L=1, O_ADDR_VALID_L=1.
  - Cache invalid.
- Reset in the middle of an access abandons it: no valid pulse, the cache is not updated, and control pins are deasserted on the next edge.

## Timing
- Miss: I_REQ is sampled at edge k.
  - SETUP spans k to k+1.
  - WAIT spans k+1 to k+1+W (W = max(P_WAIT_CYCLES,1)).
  - Data is captured at edge k+1+W.
  - O_DATA_VALID is high during cycle k+1+W to k+2+W.
  - The next request can be sampled at edge k+2+W. Throughput is one read per W+2 cycles.
- Hit (cache enabled): I_REQ at edge k gives O_DATA_VALID high during cycle k to k+1. The next request can be sampled at edge k+1.
- I_FLASH_DATA must be stable at the capture edge. Data is held OE_L-low for W cycles before that edge.
- I_REQ held high continuously is re-sampled every time the block enters IDLE, so each return to IDLE starts a new read.

## Configuration
- FLASH_READ_CACHE_EN defined:
  - One-entry cache: tag = addr[23:1], 16-bit data, valid bit.
  - A hit requires valid=1 and a tag match. Every miss capture refills the cache.
  - I_FLUSH clears valid.
  - If I_FLUSH arrives while SETUP or WAIT is in progress, a pending bit suppresses the refill at capture.
  - If I_FLUSH and I_REQ are sampled on the same edge, the flush wins and the request is handled as a miss.
- Not defined:
  - No cache storage. Every request takes the miss path.
  - I_FLUSH is ignored.

## Test plan
- Reset, then idle for 10 cycles: CE_L=OE_L=ADV_L=1, WE_L=1, O_BUSY=0, O_DATA_VALID=0, O_DATA=8'h00.
- P_WAIT_CYCLES=4, I_ADDR=24'h20_1235, flash returns 16'hBEEF: O_FLASH_ADDR=24'h10_091A, O_DATA=8'hBE, and the valid pulse arrives 6 cycles after the request edge.
- Back-to-back requests to 24'h00_0000 and 24'h00_0001 (without cache), flash returns 16'hA55A: O_DATA is 8'h5A then 8'hA5, with requests accepted 6 cycles apart.
- With FLASH_READ_CACHE_EN:
  - 24'h00_0101 (miss) followed by 24'h00_0100 gives a hit: valid arrives 1 cycle after the request edge, O_DATA is the low byte, and CE_L stays 1.
  - An I_FLUSH pulse, then 24'h00_0100 again, gives a miss with the full 6-cycle latency.
- I_FLUSH asserted during WAIT: the in-flight read still returns valid data, and a repeat of the same address misses.
- I_RESET asserted during WAIT: no O_DATA_VALID pulse, CE_L/OE_L=1 on the next edge, and the next request after reset completes normally.

Source files
------------

// File: rtl/flash_read_sequencer.sv
// flash_read_sequencer: timed byte-read sequencer for a 16-bit asynchronous
// NOR flash. Requests are accepted in IDLE, run SETUP -> WAIT -> DONE and
// return the selected byte with a one-cycle O_DATA_VALID pulse.
// Optional one-entry last-word cache: define FLASH_READ_CACHE_EN.
module flash_read_sequencer #(
  parameter int P_WAIT_CYCLES = 4
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_REQ,
  input  logic [23:0] I_ADDR,
  input  logic        I_FLUSH,
  output logic        O_BUSY,
  output logic        O_DATA_VALID,
  output logic [7:0]  O_DATA,
  input  logic [15:0] I_FLASH_DATA,
  output logic [23:0] O_FLASH_ADDR,
  output logic        O_FLASH_CLK,
  output logic        O_ADDR_VALID_L,
  output logic        O_FLASH_CE_L,
  output logic        O_FLASH_OE_L,
  output logic        O_FLASH_WE_L
);

  // A zero access time is treated as a single cycle.
  localparam int W_EFF = (P_WAIT_CYCLES < 1) ? 1 : P_WAIT_CYCLES;
  localparam int CW    = (P_WAIT_CYCLES < 1) ? 1 : $clog2(P_WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [23:0]   addr_q;
  logic          busy_q;
  logic          valid_q;
  logic [7:0]    data_q;
  logic          ce_l_q;
  logic          oe_l_q;
  logic          adv_l_q;

  logic          hit;
  logic [15:0]   cache_data;

`ifdef FLASH_READ_CACHE_EN
  logic          cache_valid;
  logic [22:0]   cache_tag;
  logic          flush_pend;
  logic          capture;

  // A flush on the same edge as a request forces the miss path.
  assign hit     = cache_valid && (cache_tag == I_ADDR[23:1]) && !I_FLUSH;
  assign capture = (state == S_WAIT) && (cnt == '0);

  // Last-word cache: refill on every miss capture unless a flush arrived
  // while that access was in flight (or on the capture edge itself).
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      flush_pend  <= 1'b0;
    end else begin
      if (capture && !flush_pend && !I_FLUSH) begin
        cache_valid <= 1'b1;
        cache_tag   <= addr_q[23:1];
        cache_data  <= I_FLASH_DATA;
      end
      if (I_FLUSH)
        cache_valid <= 1'b0;
      if (capture)
        flush_pend <= 1'b0;
      else if (I_FLUSH && (state == S_SETUP || state == S_WAIT))
        flush_pend <= 1'b1;
    end
  end
`else
  logic unused_flush;

  assign hit          = 1'b0;
  assign cache_data   = '0;
  assign unused_flush = I_FLUSH;
`endif

  // Sequencer FSM; all flash control pins are registered alongside the state.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ce_l_q  <= 1'b1;
      oe_l_q  <= 1'b1;
      adv_l_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (I_REQ) begin
            addr_q <= I_ADDR;
            busy_q <= 1'b1;
            if (hit) begin
              state   <= S_DONE;
              valid_q <= 1'b1;
              data_q  <= I_ADDR[0] ? cache_data[15:8] : cache_data[7:0];
            end else begin
              state   <= S_SETUP;
              ce_l_q  <= 1'b0;
              adv_l_q <= 1'b0;
            end
          end
        end
        S_SETUP: begin
          state   <= S_WAIT;
          adv_l_q <= 1'b1;
          oe_l_q  <= 1'b0;
          cnt     <= CNT_LOAD;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state   <= S_DONE;
            valid_q <= 1'b1;
            data_q  <= addr_q[0] ? I_FLASH_DATA[15:8] : I_FLASH_DATA[7:0];
            ce_l_q  <= 1'b1;
            oe_l_q  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign O_BUSY         = busy_q;
  assign O_DATA_VALID   = valid_q;
  assign O_DATA         = data_q;
  assign O_FLASH_ADDR   = {1'b0, addr_q[23:1]};
  assign O_FLASH_CLK    = 1'b1;
  assign O_ADDR_VALID_L = adv_l_q;
  assign O_FLASH_CE_L   = ce_l_q;
  assign O_FLASH_OE_L   = oe_l_q;
  assign O_FLASH_WE_L   = 1'b1;

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Self-checking bench for flash_read_sequencer. Adapts its expectations to
// whether FLASH_READ_CACHE_EN is defined for the build.
module tb_flash_read_sequencer;

  localparam int W = 4;
`ifdef FLASH_READ_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic        I_REQ;
  logic [23:0] I_ADDR;
  logic        I_FLUSH;
  logic        O_BUSY;
  logic        O_DATA_VALID;
  logic [7:0]  O_DATA;
  logic [15:0] I_FLASH_DATA;
  logic [23:0] O_FLASH_ADDR;
  logic        O_FLASH_CLK;
  logic        O_ADDR_VALID_L;
  logic        O_FLASH_CE_L;
  logic        O_FLASH_OE_L;
  logic        O_FLASH_WE_L;

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];

  flash_read_sequencer #(.P_WAIT_CYCLES(W)) dut (
    .I_CLK          (I_CLK),
    .I_RESET        (I_RESET),
    .I_REQ          (I_REQ),
    .I_ADDR         (I_ADDR),
    .I_FLUSH        (I_FLUSH),
    .O_BUSY         (O_BUSY),
    .O_DATA_VALID   (O_DATA_VALID),
    .O_DATA         (O_DATA),
    .I_FLASH_DATA   (I_FLASH_DATA),
    .O_FLASH_ADDR   (O_FLASH_ADDR),
    .O_FLASH_CLK    (O_FLASH_CLK),
    .O_ADDR_VALID_L (O_ADDR_VALID_L),
    .O_FLASH_CE_L   (O_FLASH_CE_L),
    .O_FLASH_OE_L   (O_FLASH_OE_L),
    .O_FLASH_WE_L   (O_FLASH_WE_L)
  );

  always #5 I_CLK = ~I_CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (observed running, expected done)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (O_BUSY !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    if (O_BUSY !== 1'b0) chk("wait_idle_busy", 32'(O_BUSY), 32'd0);
  endtask

  // flush_cyc: -1 none, 0 together with the request, n>0 asserted after
  // the n-th edge following the request edge (one cycle wide).
  task automatic do_read(input logic [23:0] addr, input logic [15:0] word,
                         input bit hit, input logic [7:0] exp, input int flush_cyc);
    int n;
    logic [7:0] e;
    wait_idle();
    I_FLASH_DATA = word;
    I_ADDR       = addr;
    I_REQ        = 1'b1;
    I_FLUSH      = (flush_cyc == 0);
    expq.push_back(exp);
    tick();
    I_REQ   = 1'b0;
    I_FLUSH = 1'b0;
    chk("flash_addr", 32'(O_FLASH_ADDR), 32'({1'b0, addr[23:1]}));
    chk("busy_after_req", 32'(O_BUSY), 32'd1);
    if (hit) begin
      chk("hit_ce_l", 32'(O_FLASH_CE_L), 32'd1);
      chk("hit_valid", 32'(O_DATA_VALID), 32'd1);
    end else begin
      chk("setup_ctl", 32'({O_FLASH_CE_L, O_FLASH_OE_L, O_ADDR_VALID_L}), 32'b010);
      n = 0;
      while (O_DATA_VALID !== 1'b1 && n < W + 1) begin
        tick();
        n++;
        if (n == 1)
          chk("wait_ctl", 32'({O_FLASH_CE_L, O_FLASH_OE_L, O_ADDR_VALID_L}), 32'b001);
        I_FLUSH = (n == flush_cyc);
      end
      I_FLUSH = 1'b0;
      chk("miss_latency", 32'(n), 32'(W + 1));
      chk("capture_ctl", 32'({O_FLASH_CE_L, O_FLASH_OE_L}), 32'b11);
    end
    e = expq.pop_front();
    if (O_DATA_VALID === 1'b1) chk("data", 32'(O_DATA), 32'(e));
    else chk("valid_missing", 32'(O_DATA_VALID), 32'd1);
    tick();
    chk("valid_pulse_end", 32'(O_DATA_VALID), 32'd0);
    chk("busy_end", 32'(O_BUSY), 32'd0);
    chk("data_hold", 32'(O_DATA), 32'(e));
  endtask

  initial begin
    I_RESET      = 1'b1;
    I_REQ        = 1'b0;
    I_ADDR       = '0;
    I_FLUSH      = 1'b0;
    I_FLASH_DATA = '0;
    repeat (3) tick();
    I_RESET = 1'b0;
    repeat (10) tick();

    // Reset / idle state
    chk("rst_ce_l", 32'(O_FLASH_CE_L), 32'd1);
    chk("rst_oe_l", 32'(O_FLASH_OE_L), 32'd1);
    chk("rst_adv_l", 32'(O_ADDR_VALID_L), 32'd1);
    chk("rst_we_l", 32'(O_FLASH_WE_L), 32'd1);
    chk("rst_fclk", 32'(O_FLASH_CLK), 32'd1);
    chk("rst_busy", 32'(O_BUSY), 32'd0);
    chk("rst_valid", 32'(O_DATA_VALID), 32'd0);
    chk("rst_data", 32'(O_DATA), 32'h00);
    chk("rst_faddr", 32'(O_FLASH_ADDR), 32'h0);

    // High byte of an odd address
    do_read(24'h20_1235, 16'hBEEF, 1'b0, 8'hBE, -1);

    // Same word, low then high byte (second hits when the cache exists)
    do_read(24'h00_0000, 16'hA55A, 1'b0, 8'h5A, -1);
    do_read(24'h00_0001, 16'hA55A, CACHE, 8'hA5, -1);

    // Miss then neighbouring byte; bus changed so a hit must come from cache
    do_read(24'h00_0101, 16'h1234, 1'b0, 8'h12, -1);
    do_read(24'h00_0100, 16'hFFFF, CACHE, CACHE ? 8'h34 : 8'hFF, -1);

    // Flush pulse in IDLE, then the same address misses
    wait_idle();
    I_FLUSH = 1'b1;
    tick();
    I_FLUSH = 1'b0;
    do_read(24'h00_0100, 16'h5678, 1'b0, 8'h78, -1);

    // Flush during WAIT: in-flight read completes, repeat misses
    do_read(24'h00_0200, 16'hCAFE, 1'b0, 8'hFE, 2);
    do_read(24'h00_0200, 16'hBABE, 1'b0, 8'hBE, -1);

    // Flush together with request: forced miss, refill still happens
    do_read(24'h00_0300, 16'h1111, 1'b0, 8'h11, -1);
    do_read(24'h00_0300, 16'h2222, 1'b0, 8'h22, 0);
    do_read(24'h00_0300, 16'h3333, CACHE, CACHE ? 8'h22 : 8'h33, -1);

    // Reset during WAIT abandons the access
    wait_idle();
    I_ADDR       = 24'h00_0400;
    I_FLASH_DATA = 16'h7777;
    I_REQ        = 1'b1;
    tick();
    I_REQ = 1'b0;
    tick();
    tick();
    I_RESET = 1'b1;
    tick();
    I_RESET = 1'b0;
    chk("abort_ce_oe_adv", 32'({O_FLASH_CE_L, O_FLASH_OE_L, O_ADDR_VALID_L}), 32'b111);
    chk("abort_busy", 32'(O_BUSY), 32'd0);
    chk("abort_valid", 32'(O_DATA_VALID), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("abort_no_valid", 32'(O_DATA_VALID), 32'd0);
    end

    // Next request after reset completes; cache was invalidated by reset
    do_read(24'h00_0401, 16'h9988, 1'b0, 8'h99, -1);
    do_read(24'h00_0300, 16'h4444, 1'b0, 8'h44, -1);

    chk("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
